rk8e_dma_break: RTL

Disk-side data-break sequencer for the RK8E option. It moves a block of 12-bit words between the disk word stream and main memory by requesting break cycles from the CPU major-state machine. In each granted DB0/DB1/DB2 sequence it presents a 15-bit memory address, and either write data or a capture point for read data. It drives the `dmaAddr`, `disk2mem` and `to_disk` inputs of the memory address/data block, and reads memory data back for disk writes.

---
 rtl/rk8e_dma_break.sv | 105 ++++++++++
 1 files changed

// File: rtl/rk8e_dma_break.sv
// rk8e_dma_break: RK8E disk data-break sequencer moving 12-bit words between the disk stream and memory.
module rk8e_dma_break #(
    parameter int MAX_LEN = 256,
    parameter logic [4:0] DB0 = 5'd8,
    parameter logic [4:0] DB2 = 5'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir,
    input  logic [0:2]  field,
    input  logic [0:11] start_addr,
    input  logic [0:8]  len,
    input  logic        abort,
    input  logic [4:0]  state,
    input  logic [0:11] mem_rdata,
    input  logic [0:11] disk_in,
    input  logic        disk_in_valid,
    output logic        disk_in_ready,
    output logic [0:11] disk_out,
    output logic        disk_out_valid,
    input  logic        disk_out_ready,
    output logic        break_req,
    output logic [0:14] dmaAddr,
    output logic [0:11] disk2mem,
    output logic        to_disk,
    output logic        busy,
    output logic        done,
    output logic        wrapped
);
    typedef enum logic [2:0] {IDLE, FILL, REQ, BRK, DRAIN} fsm_t;
    fsm_t fsm, nxt;
    logic [0:2]  field_q;
    logic [0:11] addr;
    logic [8:0]  count;
    logic        abort_q, ab, last, take, brk_end, brk_read, adv;

    always_ff @(posedge clk or negedge reset)
        if (!reset) fsm <= IDLE;
        else fsm <= nxt;

    // an abort seen at any point of a granted break is honoured only once DB2 has passed
    always_comb begin
        ab   = abort | abort_q;
        last = count == 9'd1;
        nxt  = fsm;
        case (fsm)
            IDLE:  nxt = start ? (dir ? REQ : FILL) : IDLE;
            FILL:  nxt = abort ? IDLE : disk_in_valid ? REQ : FILL;
            REQ:   nxt = abort ? IDLE : state == DB0 ? BRK : REQ;
            BRK:   nxt = state != DB2 ? BRK : ab ? IDLE : to_disk ? DRAIN : last ? IDLE : FILL;
            DRAIN: nxt = abort ? IDLE : disk_out_ready ? (last ? IDLE : REQ) : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        take     = fsm == FILL && disk_in_valid && !abort;
        brk_end  = fsm == BRK && state == DB2 && !ab;
        brk_read = brk_end && to_disk;
        adv      = (brk_end && !to_disk) || (fsm == DRAIN && disk_out_ready && !abort);
        dmaAddr  = {field_q, addr};
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            field_q        <= '0;
            addr           <= '0;
            count          <= '0;
            abort_q        <= 1'b0;
            to_disk        <= 1'b0;
            wrapped        <= 1'b0;
            disk2mem       <= '0;
            disk_out       <= '0;
            disk_out_valid <= 1'b0;
            disk_in_ready  <= 1'b0;
            break_req      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            disk_in_ready <= take;
            break_req     <= nxt == REQ;
            busy          <= nxt != IDLE;
            done          <= adv && last;
            abort_q       <= fsm == BRK && ab;
            if (fsm == IDLE && start) begin
                field_q <= field;
                addr    <= start_addr;
                to_disk <= dir;
                count   <= len == '0 ? 9'(MAX_LEN) : len;
                wrapped <= 1'b0;
            end
            if (take) disk2mem <= disk_in;
            if (brk_read) begin
                disk_out       <= mem_rdata;
                disk_out_valid <= 1'b1;
            end
            if (fsm == DRAIN && (abort || disk_out_ready)) disk_out_valid <= 1'b0;
            if (adv) begin
                addr  <= addr + 12'd1;
                count <= count - 9'd1;
                if (addr == 12'hFFF) wrapped <= 1'b1;
            end
        end
endmodule
